vga_scanout: RTL

VGA_SCANOUT -- requirements
Module: vga_scanout

---
 rtl/vga_scanout_pkg.sv | 51 +++++
 rtl/vga_sync_counter.sv | 70 +++++++
 rtl/vga_scanout.sv | 120 ++++++++++++
 3 files changed

// File: rtl/vga_scanout_pkg.sv
`default_nettype none
// ============================================================================
// vga_scanout_pkg : shared VGA timing, frame-buffer and colour definitions
// Revision 1.0
// ============================================================================
package vga_scanout_pkg;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;
  localparam int unsigned DEF_FB_COLS   = 80;
  localparam int unsigned DEF_FB_ROWS   = 60;

  localparam int unsigned HC_W   = 10;
  localparam int unsigned VC_W   = 10;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned RGB_W  = 3;

  // Colour bit order is {R, G, B}
  localparam logic [RGB_W-1:0] COLOR_BLACK   = 3'b000;
  localparam logic [RGB_W-1:0] COLOR_BLUE    = 3'b001;
  localparam logic [RGB_W-1:0] COLOR_GREEN   = 3'b010;
  localparam logic [RGB_W-1:0] COLOR_CYAN    = 3'b011;
  localparam logic [RGB_W-1:0] COLOR_RED     = 3'b100;
  localparam logic [RGB_W-1:0] COLOR_MAGENTA = 3'b101;
  localparam logic [RGB_W-1:0] COLOR_YELLOW  = 3'b110;
  localparam logic [RGB_W-1:0] COLOR_WHITE   = 3'b111;

  typedef struct packed {
    logic vis;
    logic hs_n;
    logic vs_n;
    logic first;
  } stage1_t;

  localparam stage1_t STAGE1_RESET = '{vis: 1'b0, hs_n: 1'b1, vs_n: 1'b1, first: 1'b0};

  // Each frame-buffer cell covers an 8x8 pixel block
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [HC_W-1:0] hc,
                                                  input logic [VC_W-1:0] vc,
                                                  input int unsigned     cols);
    return ADDR_W'((32'(vc) >> 3) * cols + (32'(hc) >> 3));
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_counter.sv
`default_nettype none
// ============================================================================
// vga_sync_counter : horizontal/vertical raster counters with raw sync/visible
// Revision 1.0
// ============================================================================
module vga_sync_counter
  import vga_scanout_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            pix_en,
  output logic [HC_W-1:0] hc,
  output logic [VC_W-1:0] vc,
  output logic            visible,
  output logic            hs_n,
  output logic            vs_n
);

  localparam logic [HC_W-1:0] H_LAST   = HC_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [VC_W-1:0] V_LAST   = VC_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [HC_W-1:0] H_VIS    = HC_W'(H_VISIBLE);
  localparam logic [VC_W-1:0] V_VIS    = VC_W'(V_VISIBLE);
  localparam logic [HC_W-1:0] HS_START = HC_W'(H_VISIBLE + H_FRONT);
  localparam logic [HC_W-1:0] HS_END   = HC_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VC_W-1:0] VS_START = VC_W'(V_VISIBLE + V_FRONT);
  localparam logic [VC_W-1:0] VS_END   = VC_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [HC_W-1:0] hc_q, hc_d;
  logic [VC_W-1:0] vc_q, vc_d;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (pix_en) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + VC_W'(1);
      end else begin
        hc_d = hc_q + HC_W'(1);
      end
    end
  end

  assign hc      = hc_q;
  assign vc      = vc_q;
  assign visible = (hc_q < H_VIS) && (vc_q < V_VIS);
  assign hs_n    = !((hc_q >= HS_START) && (hc_q < HS_END));
  assign vs_n    = !((vc_q >= VS_START) && (vc_q < VS_END));

endmodule
`default_nettype wire

// File: rtl/vga_scanout.sv
`default_nettype none
// ============================================================================
// vga_scanout : 640x480 text-cell scan-out with two-stage video-RAM pipeline
// Revision 1.0
// ============================================================================
module vga_scanout
  import vga_scanout_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter int unsigned FB_COLS   = DEF_FB_COLS,
  parameter int unsigned FB_ROWS   = DEF_FB_ROWS
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic [ADDR_W-1:0] oReadAddress,
  input  logic [RGB_W-1:0]  iReadData,
  output logic              oVGA_R,
  output logic              oVGA_G,
  output logic              oVGA_B,
  output logic              oVGA_HS,
  output logic              oVGA_VS,
  output logic              oFrameStart
);

  logic              pix_en_q, pix_en_d;
  logic [HC_W-1:0]   hc;
  logic [VC_W-1:0]   vc;
  logic              visible;
  logic              hs_raw_n;
  logic              vs_raw_n;
  logic              in_fb;
  stage1_t           s1_q, s1_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RGB_W-1:0]  rgb_q, rgb_d;
  logic              hs_q, hs_d;
  logic              vs_q, vs_d;
  logic              fs_q, fs_d;

  vga_sync_counter #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK)
  ) u_sync (
    .Clock   (Clock),
    .Reset   (Reset),
    .pix_en  (pix_en_q),
    .hc      (hc),
    .vc      (vc),
    .visible (visible),
    .hs_n    (hs_raw_n),
    .vs_n    (vs_raw_n)
  );

  // Keeps the read address inside the frame buffer if timing and cell geometry disagree
  assign in_fb = ((32'(hc) >> 3) < FB_COLS) && ((32'(vc) >> 3) < FB_ROWS);

  always_comb begin
    pix_en_d = ~pix_en_q;
    s1_d     = s1_q;
    addr_d   = addr_q;
    rgb_d    = rgb_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    fs_d     = 1'b0;
    if (pix_en_q) begin
      s1_d.vis   = visible;
      s1_d.hs_n  = hs_raw_n;
      s1_d.vs_n  = vs_raw_n;
      s1_d.first = (hc == '0) && (vc == '0);
      if (visible && in_fb) begin
        addr_d = cell_addr(hc, vc, FB_COLS);
      end
      // RAM data for the stage-1 address arrives one Clock later, in time for this edge
      rgb_d = s1_q.vis ? iReadData : COLOR_BLACK;
      hs_d  = s1_q.hs_n;
      vs_d  = s1_q.vs_n;
      fs_d  = s1_q.first;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pix_en_q <= 1'b0;
      s1_q     <= STAGE1_RESET;
      addr_q   <= '0;
      rgb_q    <= COLOR_BLACK;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      fs_q     <= 1'b0;
    end else begin
      pix_en_q <= pix_en_d;
      s1_q     <= s1_d;
      addr_q   <= addr_d;
      rgb_q    <= rgb_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      fs_q     <= fs_d;
    end
  end

  assign oReadAddress              = addr_q;
  assign {oVGA_R, oVGA_G, oVGA_B}  = rgb_q;
  assign oVGA_HS                   = hs_q;
  assign oVGA_VS                   = vs_q;
  assign oFrameStart               = fs_q;

endmodule
`default_nettype wire
